// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : First-word-fall-through receive buffer for a UART receiver.
//             Stores bytes on rx_done_tick, exposes the head combinationally,
//             and reports fill level plus a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [ADDR_W:0]   level_next;

  // A pop needs data; a write needs space, except when a pop frees a slot
  // in the same cycle (full with rd: the freed slot is reused).
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || rd);

  // Next fill level; gating above keeps it within 0..DEPTH.
  always_comb begin
    level_next = level;
    case ({do_wr, do_rd})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Head entry is visible without a read request.
  assign r_data = mem[r_ptr];

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[w_ptr] <= w_data;
    end
  end

  // Pointers, level and the flags derived from the next level.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == DEPTH_LVL);
    end
  end

  // Sticky overrun: a dropped write sets it and takes priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (wr && full && !rd) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       rd = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; w_data = d; rd = r; clr_overrun = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0; w_data = 8'h00;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    bit         rd_now;

    // ---- reset state
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);

    // ---- 1: single write then read
    cyc(1, 8'hA5, 0, 0);
    check("t1_empty", empty, 0);
    check("t1_level", level, 1);
    check("t1_rdata", r_data, 8'hA5);
    cyc(0, 8'h00, 1, 0);
    check("t1_empty_after_rd", empty, 1);
    check("t1_level_after_rd", level, 0);

    // ---- 2: fill to 16
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    check("t2_full", full, 1);
    check("t2_level", level, 16);
    check("t2_head", r_data, 8'h00);

    // ---- 3: write while full is dropped
    cyc(1, 8'h55, 0, 0);
    check("t3_overrun", overrun, 1);
    check("t3_level", level, 16);
    check("t3_head", r_data, 8'h00);
    cyc(1, 8'h66, 0, 1);
    check("t3_set_wins", overrun, 1);
    check("t3_level2", level, 16);
    cyc(0, 8'h00, 0, 1);
    check("t3_cleared", overrun, 0);

    // ---- 4: simultaneous write and pop while full
    cyc(1, 8'h77, 1, 0);
    check("t4_level", level, 16);
    check("t4_full", full, 1);
    check("t4_overrun", overrun, 0);
    check("t4_head", r_data, 8'h01);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 1) : 8'h77;
      check("t4_order", r_data, exp_b);
      cyc(0, 8'h00, 1, 0);
    end
    check("t4_empty", empty, 1);
    check("t4_level_end", level, 0);

    // ---- 5: write and pop on empty FIFO; pop while empty
    cyc(1, 8'h3C, 1, 0);
    check("t5_level", level, 1);
    check("t5_rdata", r_data, 8'h3C);
    check("t5_empty", empty, 0);
    cyc(0, 8'h00, 1, 0);
    check("t5_level0", level, 0);
    cyc(0, 8'h00, 1, 0);
    check("t5_rd_empty_level", level, 0);
    check("t5_rd_empty_empty", empty, 1);
    check("t5_rd_empty_full", full, 0);
    check("t5_rd_empty_ovr", overrun, 0);

    // ---- 6: interleaved traffic wrapping the pointers
    for (int i = 0; i < 25; i++) begin
      rd_now = (i % 3 != 0) && (q.size() > 0);
      if (q.size() > 0) check("t6_head", r_data, q[0]);
      cyc(1, 8'h80 + 8'(i), rd_now, 0);
      if (rd_now) void'(q.pop_front());
      q.push_back(8'h80 + 8'(i));
      check("t6_level", level, q.size());
    end
    check("t6_level9", level, 9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_rst_level", level, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_full", full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
